branch_predict_unit: RTL

- Parametrised successor to the combinational jump-decision logic.
- Performs full RV32I branch-condition evaluation for all six branch types, with separate signed and unsigned less-than flags.
- Adds a BHT_DEPTH-entry table of 2-bit saturating counters indexed by PC for fetch-stage prediction, plus EX-stage misprediction/flush generation and saturating performance counters.
- Sits between the fetch PC mux (prediction) and the EX stage (resolution).

---
 rtl/branch_predict_unit_if.sv | 39 +++
 rtl/branch_predict_unit.sv | 97 +++++++++
 2 files changed

// File: rtl/branch_predict_unit_if.sv
// Fetch-side prediction and EX-side resolution signals of the branch predict unit.
interface branch_predict_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic [XLEN-1:0]  fetch_pc;
  logic             predict_taken;
  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc;
  logic             ex_branch;
  logic             ex_jump;
  logic [2:0]       ex_funct3;
  logic             ex_pred_taken;
  logic             zf;
  logic             slt;
  logic             sltu;
  logic             should_jump;
  logic             mispredict;
  logic             flush;
  logic             illegal_branch;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  // Pipeline side: supplies PCs and EX operands, consumes decisions.
  modport master (
    output fetch_pc, ex_valid, ex_pc, ex_branch, ex_jump, ex_funct3,
           ex_pred_taken, zf, slt, sltu,
    input  predict_taken, should_jump, mispredict, flush, illegal_branch,
           branch_count, mispredict_count
  );

  // Predictor side.
  modport slave (
    input  fetch_pc, ex_valid, ex_pc, ex_branch, ex_jump, ex_funct3,
           ex_pred_taken, zf, slt, sltu,
    output predict_taken, should_jump, mispredict, flush, illegal_branch,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predict_unit.sv
// RV32I branch resolution with a 2-bit saturating-counter BHT for fetch
// prediction, misprediction/flush generation and saturating perf counters.
module branch_predict_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned CNT_W     = 32,
  parameter logic [1:0]  BHT_INIT  = 2'b01
) (
  input logic                clk,
  input logic                rst,
  branch_predict_unit_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       bht_q [BHT_DEPTH];
  logic [1:0]       entry_d;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_q;

  logic [XLEN-1:0]  fetch_pc_w;
  logic [XLEN-1:0]  ex_pc_w;
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             br_cond;
  logic             reserved;
  logic             ex_br;
  logic             should_jump;
  logic             mispredict;
  logic             upd;

  assign fetch_pc_w = bus.fetch_pc;
  assign ex_pc_w    = bus.ex_pc;
  // Word-aligned index: drop the two byte-offset bits, keep IDX_W bits.
  assign fetch_idx  = IDX_W'(fetch_pc_w >> 2);
  assign ex_idx     = IDX_W'(ex_pc_w >> 2);

  // Decode funct3 into the raw branch condition.
  always_comb begin
    br_cond  = 1'b0;
    reserved = 1'b0;
    case (bus.ex_funct3)
      3'b000:  br_cond = bus.zf;
      3'b001:  br_cond = !bus.zf;
      3'b100:  br_cond = bus.slt;
      3'b101:  br_cond = !bus.slt;
      3'b110:  br_cond = bus.sltu;
      3'b111:  br_cond = !bus.sltu;
      default: reserved = 1'b1;
    endcase
  end

  // Resolution: a jump overrides any branch qualifier on the same instruction.
  always_comb begin
    ex_br       = bus.ex_valid & bus.ex_branch;
    should_jump = bus.ex_valid & (bus.ex_jump | (bus.ex_branch & br_cond & !reserved));
    upd         = ex_br & !bus.ex_jump & !reserved;
    mispredict  = upd & (should_jump != bus.ex_pred_taken);
  end

  assign bus.predict_taken    = bht_q[fetch_idx][1];
  assign bus.should_jump      = should_jump;
  assign bus.mispredict       = mispredict;
  assign bus.flush            = mispredict | (bus.ex_valid & bus.ex_jump);
  assign bus.illegal_branch   = ex_br & reserved;
  assign bus.branch_count     = branch_cnt_q;
  assign bus.mispredict_count = mispred_cnt_q;

  // Saturating step of the counter addressed by the resolving branch.
  always_comb begin
    entry_d = bht_q[ex_idx];
    if (should_jump) begin
      if (entry_d != 2'b11) entry_d = entry_d + 2'b01;
    end else begin
      if (entry_d != 2'b00) entry_d = entry_d - 2'b01;
    end
  end

  // BHT write; the fetch read is unbypassed so a colliding read sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) bht_q[i] <= BHT_INIT;
    end else if (upd) begin
      bht_q[ex_idx] <= entry_d;
    end
  end

  // Performance counters, holding at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (upd && branch_cnt_q != '1)        branch_cnt_q  <= branch_cnt_q + 1'b1;
      if (mispredict && mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + 1'b1;
    end
  end
endmodule
